// File: rtl/genesis_pad_responder.sv
// Pad side of the Genesis/SMS controller port: emulates an SMS, 3-button or 6-button pad on six active-low data lines.
// Latency: TH edge to pins SYNC_STAGES+1 cycles, buttons to pins 1 cycle; no backpressure, the console samples whenever it likes.
module genesis_pad_responder #(
  parameter int TIMEOUT_CYCLES = 75000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        iCLK,
  input  logic        iRESET,
  input  logic [1:0]  iPADTYPE,
  input  logic        iSELECT,
  input  logic [11:0] iBUTTONS,
  output logic [5:0]  oGENPAD,
  output logic [2:0]  oPHASE
);

  typedef enum logic [1:0] {
    PAD_SMS  = 2'b00,
    PAD_3BTN = 2'b01,
    PAD_6BTN = 2'b10,
    PAD_NONE = 2'b11
  } pad_type_e;

  localparam logic [16:0] TMO_MAX = 17'(TIMEOUT_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sel_d;
  logic                   sel_s;
  logic                   sel_edge;
  logic                   sel_rise;
  logic [1:0]             type_q;
  logic                   type_chg;
  pad_type_e              pad_type;
  logic [16:0]            tmo_q;
  logic [16:0]            tmo_n;
  logic                   to_hit;
  logic [2:0]             phase_n;
  logic [5:0]             std_hi;
  logic [5:0]             std_lo;
  logic [5:0]             std_vec;
  logic [5:0]             pad_vec;

  assign sel_s    = sync_q[SYNC_STAGES-1];
  assign sel_edge = sel_s ^ sel_d;
  assign sel_rise = sel_s & ~sel_d;
  assign pad_type = pad_type_e'(iPADTYPE);
  assign type_chg = (iPADTYPE != type_q);

  // Button order {Z,Y,X,M,S,C,B,A,U,D,L,R}; vectors are active-high before the final inversion
  assign std_hi  = {iBUTTONS[6], iBUTTONS[5], iBUTTONS[3], iBUTTONS[2], iBUTTONS[1], iBUTTONS[0]};
  assign std_lo  = {iBUTTONS[7], iBUTTONS[4], iBUTTONS[3], iBUTTONS[2], 2'b11};
  assign std_vec = sel_s ? std_hi : std_lo;

  always_comb begin
    to_hit  = (tmo_q == TMO_MAX);
    phase_n = 3'd0;
    tmo_n   = 17'd0;
    // A type switch discards any in-flight edge and restarts the sequencer
    if (pad_type == PAD_6BTN && !type_chg) begin
      phase_n = to_hit ? 3'd0 : oPHASE;
      if (sel_edge) begin
        phase_n = phase_n + 3'd1;
      end
      tmo_n = (sel_rise || to_hit) ? 17'd0 : tmo_q + 17'd1;
    end
  end

  always_comb begin
    pad_vec = 6'b000000;
    case (pad_type)
      PAD_SMS:  pad_vec = std_hi;
      PAD_3BTN: pad_vec = std_vec;
      PAD_6BTN: begin
        case (phase_n)
          3'd3:    pad_vec = {iBUTTONS[7], iBUTTONS[4], 4'b1111};
          3'd4:    pad_vec = {iBUTTONS[6], iBUTTONS[5], iBUTTONS[11], iBUTTONS[10], iBUTTONS[9], iBUTTONS[8]};
          3'd5:    pad_vec = {iBUTTONS[7], iBUTTONS[4], 4'b0000};
          default: pad_vec = std_vec;
        endcase
      end
      default:  pad_vec = 6'b000000;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      sync_q  <= '1;
      sel_d   <= 1'b1;
      type_q  <= PAD_NONE;
      tmo_q   <= 17'd0;
      oPHASE  <= 3'd0;
      oGENPAD <= 6'b111111;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], iSELECT};
      sel_d   <= sel_s;
      type_q  <= iPADTYPE;
      tmo_q   <= tmo_n;
      oPHASE  <= phase_n;
      oGENPAD <= ~pad_vec;
    end
  end

endmodule

// File: tb/tb_genesis_pad_responder.sv
// Directed bench for genesis_pad_responder: expected pin/phase values are queued as stimulus is driven
// and popped once the responder has had time to react.
module tb_genesis_pad_responder;

  localparam int T = 200;

  logic        fpga_clk_50;
  logic        reset;
  logic [1:0]  pad_type;
  logic        select;
  logic [11:0] buttons;
  logic [5:0]  genpad;
  logic [2:0]  phase;

  int checks = 0;
  int errors = 0;

  logic [5:0] q_gp[$];
  logic [2:0] q_ph[$];
  string      q_tag[$];

  genesis_pad_responder #(
    .TIMEOUT_CYCLES(T),
    .SYNC_STAGES(2)
  ) dut (
    .iCLK(fpga_clk_50),
    .iRESET(reset),
    .iPADTYPE(pad_type),
    .iSELECT(select),
    .iBUTTONS(buttons),
    .oGENPAD(genpad),
    .oPHASE(phase)
  );

  initial fpga_clk_50 = 1'b0;
  always #10 fpga_clk_50 = ~fpga_clk_50;

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic sb_push(input string tag, input logic [5:0] gp, input logic [2:0] ph);
    q_tag.push_back(tag);
    q_gp.push_back(gp);
    q_ph.push_back(ph);
  endtask

  task automatic sb_check();
    string      tag;
    logic [5:0] egp;
    logic [2:0] eph;
    if (q_tag.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty got no expectation, required one");
    end else begin
      tag = q_tag.pop_front();
      egp = q_gp.pop_front();
      eph = q_ph.pop_front();
      checks++;
      assert (genpad === egp) else begin
        errors++;
        $error("FAIL %s oGENPAD got %b required %b", tag, genpad, egp);
      end
      checks++;
      assert (phase === eph) else begin
        errors++;
        $error("FAIL %s oPHASE got %0d required %0d", tag, phase, eph);
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge fpga_clk_50);
  endtask

  initial begin
    int k;
    logic       ph3_seen;
    logic [5:0] egp;

    // Reset held with TH toggling
    reset    = 1'b1;
    pad_type = 2'b10;
    buttons  = 12'h000;
    select   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge fpga_clk_50);
      sb_push($sformatf("reset_%0d", i), 6'b111111, 3'd0);
      sb_check();
      select = ~select;
    end
    reset = 1'b0;
    sb_push("reset_release", 6'b111111, 3'd0);
    cyc(1);
    sb_check();

    // SMS pad: TH has no effect
    pad_type = 2'b00;
    buttons  = 12'h021;
    select   = 1'b1;
    cyc(5);
    for (int i = 0; i < 10; i++) begin
      select = ~select;
      sb_push($sformatf("sms_t%0d", i), 6'b101110, 3'd0);
      cyc(4);
      sb_check();
    end
    buttons = 12'h040;
    sb_push("sms_btn_lat1", 6'b011111, 3'd0);
    cyc(1);
    sb_check();

    // 3-button pad, including the exact TH latency
    pad_type = 2'b01;
    buttons  = 12'h090;
    select   = 1'b1;
    sb_push("b3_hi", 6'b111111, 3'd0);
    cyc(5);
    sb_check();
    select = 1'b0;
    sb_push("b3_lo_lat2", 6'b111111, 3'd0);
    cyc(2);
    sb_check();
    sb_push("b3_lo_lat3", 6'b001100, 3'd0);
    cyc(1);
    sb_check();
    select = 1'b1;
    sb_push("b3_hi_again", 6'b111111, 3'd0);
    cyc(3);
    sb_check();

    // 6-button pad: full 8-edge cycle, 1 us per half period
    pad_type = 2'b10;
    buttons  = 12'hA00;
    select   = 1'b1;
    cyc(5);
    for (int e = 1; e <= 8; e++) begin
      select = ~select;
      case (e)
        1: egp = 6'b111100;
        2: egp = 6'b111111;
        3: egp = 6'b110000;
        4: egp = 6'b110101;
        5: egp = 6'b111111;
        6: egp = 6'b111111;
        7: egp = 6'b111100;
        default: egp = 6'b111111;
      endcase
      sb_push($sformatf("six_e%0d", e), egp, 3'(e % 8));
      cyc(50);
      sb_check();
    end

    // Timeout: fall, rise, fall, then hold TH low
    buttons = 12'h000;
    select  = 1'b0;
    sb_push("tmo_ph1", 6'b111100, 3'd1);
    cyc(10);
    sb_check();
    select = 1'b1;
    k = 0;
    while (phase !== 3'd2 && k < 10) begin
      cyc(1);
      k++;
    end
    checks++;
    assert (phase === 3'd2) else begin
      errors++;
      $error("FAIL tmo_ph2 oPHASE got %0d required 2", phase);
    end
    k = 0;
    ph3_seen = 1'b0;
    while (phase !== 3'd0 && k < T + 50) begin
      cyc(1);
      k++;
      if (k == 10) select = 1'b0;
      if (k == 30) ph3_seen = (phase === 3'd3);
    end
    checks++;
    assert (ph3_seen === 1'b1) else begin
      errors++;
      $error("FAIL tmo_ph3 phase 3 seen got %b required 1", ph3_seen);
    end
    checks++;
    assert (k == T + 1) else begin
      errors++;
      $error("FAIL tmo_cycles got %0d required %0d", k, T + 1);
    end
    sb_push("tmo_out", 6'b111100, 3'd0);
    sb_check();
    select = 1'b1;
    sb_push("tmo_next_edge", 6'b111111, 3'd1);
    cyc(3);
    sb_check();
    select = 1'b0;
    sb_push("tmo_edge2", 6'b111100, 3'd2);
    cyc(3);
    sb_check();

    // Mid-sequence reset with TH low, then a type change at phase 4
    buttons = 12'hA60;
    reset   = 1'b1;
    sb_push("rst_mid", 6'b111111, 3'd0);
    cyc(1);
    sb_check();
    reset = 1'b0;
    sb_push("rst_first_edge", 6'b111100, 3'd1);
    cyc(5);
    sb_check();
    select = 1'b1;
    cyc(5);
    select = 1'b0;
    cyc(5);
    select = 1'b1;
    sb_push("chg_ph4", 6'b000101, 3'd4);
    cyc(5);
    sb_check();
    pad_type = 2'b01;
    sb_push("chg_to_3btn", 6'b001111, 3'd0);
    cyc(1);
    sb_check();
    select = 1'b0;
    sb_push("chg_3btn_lo", 6'b111100, 3'd0);
    cyc(3);
    sb_check();

    // Disconnected pad
    pad_type = 2'b11;
    buttons  = 12'hFFF;
    sb_push("none", 6'b111111, 3'd0);
    cyc(2);
    sb_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
